alu_add8s: RTL and testbench

- Bit-serial 8-bit add/subtract engine for the 8085 core datapath, built around the existing 1-bit full adder (add1b).
- Accepts a start pulse with two operands, shifts them LSB-first through one add1b instance, one bit per clock.
- Returns the 8-bit result plus the 8085 arithmetic flags (CY, AC, Z, S, P) with a done pulse.
- Sits between operand registers (A/temp) and the accumulator/flag register writeback.

---
 rtl/alu_add8s_pkg.sv | 34 +++
 rtl/add1b.sv | 15 +
 rtl/alu_add8s.sv | 107 ++++++++++
 tb/tb_alu_add8s.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_add8s_pkg.sv
// Shared definitions for the bit-serial 8085 add/subtract engine.
// State encodings and 8085 flag register bit positions.
package alu_add8s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int FLAG_S  = 7;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_AC = 4;
    localparam int FLAG_P  = 2;
    localparam int FLAG_CY = 0;

    function automatic logic [7:0] pack_flags(
        input logic s,
        input logic z,
        input logic ac,
        input logic p,
        input logic cy
    );
        logic [7:0] f;
        f = '0;
        f[FLAG_S]  = s;
        f[FLAG_Z]  = z;
        f[FLAG_AC] = ac;
        f[FLAG_P]  = p;
        f[FLAG_CY] = cy;
        return f;
    endfunction

endpackage

// File: rtl/add1b.sv
// 1-bit full adder with propagate output.
module add1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout,
    output logic p
);

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (p & cin);

endmodule

// File: rtl/alu_add8s.sv
// Bit-serial add/subtract engine: one bit per clock through a single add1b,
// reporting result plus 8085 CY/AC/Z/S/P flags with a done pulse.
module alu_add8s
    import alu_add8s_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             iCLK,
    input  logic             iRSTn,
    input  logic             iStart,
    input  logic             iSub,
    input  logic             iCin,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oRes,
    output logic             oCY,
    output logic             oAC,
    output logic             oZ,
    output logic             oS,
    output logic             oP
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    cnt;
    logic             c_q;
    logic             ac_q;
    logic             sub_q;
    logic             sum;
    logic             cout;
    logic             p_unused;

    add1b u_add (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (c_q),
        .s    (sum),
        .cout (cout),
        .p    (p_unused)
    );

    assign oBusy = (state == ST_SHIFT) || (state == ST_DONE);

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state <= ST_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            cnt   <= '0;
            c_q   <= 1'b0;
            ac_q  <= 1'b0;
            sub_q <= 1'b0;
            oDone <= 1'b0;
            oRes  <= '0;
            oCY   <= 1'b0;
            oAC   <= 1'b0;
            oZ    <= 1'b0;
            oS    <= 1'b0;
            oP    <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        // Subtract runs as A + ~B + ~borrow.
                        a_q   <= iA;
                        b_q   <= iSub ? ~iB : iB;
                        c_q   <= iCin ^ iSub;
                        sub_q <= iSub;
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_q <= {sum, r_q[WIDTH-1:1]};
                    a_q <= a_q >> 1;
                    b_q <= b_q >> 1;
                    c_q <= cout;
                    if (cnt == CW'(3))
                        ac_q <= cout;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    oRes  <= r_q;
                    oCY   <= c_q ^ sub_q;
                    oAC   <= ac_q;
                    oZ    <= ~|r_q;
                    oS    <= r_q[WIDTH-1];
                    oP    <= ~^r_q;
                    oDone <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_add8s.sv
// Self-checking bench for alu_add8s: directed steps plus a scoreboard
// of expected {res, CY, AC, Z, S, P} popped on every done pulse.
module tb_alu_add8s;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] res;
    logic       cy;
    logic       ac;
    logic       z;
    logic       s;
    logic       p;

    int checks   = 0;
    int failures = 0;

    logic [12:0] sb_q[$];
    logic [12:0] exp_v;

    alu_add8s #(.WIDTH(8)) dut (
        .iCLK   (clk),
        .iRSTn  (rst_n),
        .iStart (start),
        .iSub   (sub),
        .iCin   (cin),
        .iA     (a),
        .iB     (b),
        .oBusy  (busy),
        .oDone  (done),
        .oRes   (res),
        .oCY    (cy),
        .oAC    (ac),
        .oZ     (z),
        .oS     (s),
        .oP     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer add/subtract, borrow as sign of the difference.
    function automatic logic [12:0] model(input logic [7:0] x,
                                          input logic [7:0] y,
                                          input logic ci,
                                          input logic sb);
        logic [8:0] t;
        logic [4:0] n;
        logic [3:0] ny;
        logic [7:0] r;
        logic       c;
        logic       h;
        if (!sb) begin
            t = {1'b0, x} + {1'b0, y} + {8'd0, ci};
            n = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'd0, ci};
        end else begin
            t  = {1'b0, x} - {1'b0, y} - {8'd0, ci};
            ny = ~y[3:0];
            n  = {1'b0, x[3:0]} + {1'b0, ny} + {4'd0, ~ci};
        end
        r = t[7:0];
        c = t[8];
        h = n[4];
        return {r, c, h, (r == 8'd0), r[7], ~^r};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_v = sb_q.pop_front();
                chk("result_flags", {19'd0, res, cy, ac, z, s, p},
                    {19'd0, exp_v});
            end
        end
    end

    // Called at a negedge; returns at the next negedge with start dropped.
    task automatic start_op(input logic [7:0] x, input logic [7:0] y,
                            input logic ci, input logic sb,
                            input bit push);
        a     = x;
        b     = y;
        cin   = ci;
        sub   = sb;
        start = 1'b1;
        if (push)
            sb_q.push_back(model(x, y, ci, sb));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        if (!done)
            chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          input logic ci, input logic sb);
        int n;
        start_op(x, y, ci, sb, 1'b1);
        wait_done(n);
        chk("latency", n, 32'd9);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    logic [7:0] corners[7];
    int         n;
    bit         saw_done;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        corners = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h0F, 8'hF0, 8'h01};

        #12;
        chk("reset_outputs", {20'd0, res, cy, ac, z, s, p, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD 0x3A+0x4C with cycle-by-cycle busy/done timing.
        start_op(8'h3A, 8'h4C, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            chk("busy_high", busy, 32'd1);
            chk("done_low_early", done, 32'd0);
            @(negedge clk);
        end
        chk("done_pulse", done, 32'd1);
        chk("busy_low_at_done", busy, 32'd0);
        chk("res_3a_4c", res, 32'h86);
        @(negedge clk);
        chk("done_one_cycle", done, 32'd0);
        @(negedge clk);
        chk("res_holds", res, 32'h86);

        // Back-to-back: each run_op starts on the done cycle of the last.
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        chk("wrap_zero", {res, cy, z}, {22'd0, 8'h00, 1'b1, 1'b1});
        run_op(8'h05, 8'h07, 1'b0, 1'b1);
        chk("sub_borrow", {res, cy}, {23'd0, 8'hFE, 1'b1});
        run_op(8'h10, 8'h01, 1'b1, 1'b1);
        chk("sbb_result", {res, cy}, {23'd0, 8'h0E, 1'b0});

        // Second start during SHIFT with different operands is ignored.
        start_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        a     = 8'h77;
        b     = 8'h11;
        sub   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk("ignored_start", res, 32'h46);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("no_queued_op", saw_done, 32'd0);

        // Reset during the 4th SHIFT cycle aborts with no done.
        start_op(8'h3A, 8'h4C, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {20'd0, res, cy, ac, z, s, p, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 32'd0);
        run_op(8'h01, 8'h01, 1'b0, 1'b0);
        chk("post_reset_op", res, 32'h02);

        // Corner operand pairs across both carry-ins and both modes.
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7; j++)
                for (int k = 0; k < 4; k++)
                    run_op(corners[i], corners[j], k[0], k[1]);

        for (int i = 0; i < 800; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
